// File: rtl/clk_gate_sequencer.sv
// Drives the CE pin of a global clock buffer: debounces key_en, then sequences
// OFF -> ON -> DRAIN (stop handshake) -> HOLD_OFF with dwell and timeout limits.
module clk_gate_sequencer #(
    parameter int DB_CYCLES   = 16,
    parameter int MIN_ON      = 32,
    parameter int MIN_OFF     = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_en,
    input  logic       stop_ack,
    output logic       ce,
    output logic       stop_req,
    output logic       en_filtered,
    output logic [1:0] state_o,
    output logic       timeout_o
);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int ONW = $clog2(MIN_ON + 1);
    localparam int OFW = $clog2(MIN_OFF + 1);
    localparam int TOW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [ONW-1:0] ON_LAST  = ONW'(MIN_ON - 1);
    localparam logic [ONW-1:0] ON_SAT   = ONW'(MIN_ON);
    localparam logic [OFW-1:0] OFF_LAST = OFW'(MIN_OFF - 1);
    localparam logic [TOW-1:0] TO_LAST  = TOW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    logic           sync1_reg, sync2_reg;
    logic [DBW-1:0] db_cnt_reg;
    state_t         state_reg, state_next;
    logic [ONW-1:0] dwell_reg, dwell_next;
    logic [TOW-1:0] wait_reg, wait_next;
    logic [OFW-1:0] hold_reg, hold_next;
    logic           ce_next, stop_req_next, timeout_next;

    assign state_o = state_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            db_cnt_reg  <= '0;
            en_filtered <= 1'b0;
            state_reg   <= ST_OFF;
            dwell_reg   <= '0;
            wait_reg    <= '0;
            hold_reg    <= '0;
            ce          <= 1'b0;
            stop_req    <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            sync1_reg <= key_en;
            sync2_reg <= sync1_reg;
            // Any agreeing sample restarts the stability run.
            if (sync2_reg == en_filtered) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                en_filtered <= ~en_filtered;
                db_cnt_reg  <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + DBW'(1);
            end
            state_reg <= state_next;
            dwell_reg <= dwell_next;
            wait_reg  <= wait_next;
            hold_reg  <= hold_next;
            ce        <= ce_next;
            stop_req  <= stop_req_next;
            timeout_o <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        dwell_next   = dwell_reg;
        wait_next    = wait_reg;
        hold_next    = hold_reg;
        timeout_next = 1'b0;
        case (state_reg)
            ST_OFF: begin
                if (en_filtered) begin
                    state_next = ST_ON;
                    dwell_next = '0;
                end
            end
            ST_ON: begin
                // dwell holds completed ON cycles minus one at the deciding edge
                if (!en_filtered && dwell_reg >= ON_LAST) begin
                    state_next = ST_DRAIN;
                    wait_next  = '0;
                end else if (dwell_reg != ON_SAT) begin
                    dwell_next = dwell_reg + ONW'(1);
                end
            end
            ST_DRAIN: begin
                if (stop_ack) begin
                    state_next = ST_HOLD;
                    hold_next  = '0;
                end else if (en_filtered) begin
                    state_next = ST_ON;
                    dwell_next = '0;
                end else if (wait_reg == TO_LAST) begin
                    state_next   = ST_HOLD;
                    hold_next    = '0;
                    timeout_next = 1'b1;
                end else begin
                    wait_next = wait_reg + TOW'(1);
                end
            end
            ST_HOLD: begin
                if (hold_reg == OFF_LAST) begin
                    state_next = ST_OFF;
                end else begin
                    hold_next = hold_reg + OFW'(1);
                end
            end
            default: state_next = ST_OFF;
        endcase
        ce_next       = (state_next == ST_ON) || (state_next == ST_DRAIN);
        stop_req_next = (state_next == ST_DRAIN);
    end
endmodule

// File: tb/tb_clk_gate_sequencer.sv
// Directed bench for clk_gate_sequencer: a time-in-state reference model is
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_clk_gate_sequencer;
    localparam int DB = 4;
    localparam int MON = 8;
    localparam int MOFF = 6;
    localparam int ATO = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_en = 1'b0;
    logic       stop_ack = 1'b0;
    logic       ce, stop_req, en_filtered, timeout_o;
    logic [1:0] state_o;

    int checks = 0;
    int passes = 0;

    clk_gate_sequencer #(
        .DB_CYCLES(DB), .MIN_ON(MON), .MIN_OFF(MOFF), .ACK_TIMEOUT(ATO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_en(key_en), .stop_ack(stop_ack),
        .ce(ce), .stop_req(stop_req), .en_filtered(en_filtered),
        .state_o(state_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // Reference model: edge counter plus timestamps of the last agreeing
    // sample and of state entry; transitions decided from elapsed cycles.
    logic       k1, k2, m_en, m_to;
    logic [1:0] m_state;
    int         cyc, last_same, m_entry;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k1 <= 1'b0; k2 <= 1'b0; m_en <= 1'b0; m_to <= 1'b0;
            m_state <= 2'd0; cyc <= 0; last_same <= 0; m_entry <= 0;
        end else begin
            k1  <= key_en;
            k2  <= k1;
            cyc <= cyc + 1;
            if (k2 == m_en) begin
                last_same <= cyc + 1;
            end else if (cyc + 1 - last_same >= DB) begin
                m_en      <= !m_en;
                last_same <= cyc + 1;
            end
            m_to <= 1'b0;
            case (m_state)
                2'd0: if (m_en) begin m_state <= 2'd1; m_entry <= cyc + 1; end
                2'd1: if (!m_en && (cyc + 1 - m_entry >= MON)) begin
                    m_state <= 2'd2; m_entry <= cyc + 1;
                end
                2'd2: begin
                    if (stop_ack) begin
                        m_state <= 2'd3; m_entry <= cyc + 1;
                    end else if (m_en) begin
                        m_state <= 2'd1; m_entry <= cyc + 1;
                    end else if (cyc + 1 - m_entry >= ATO) begin
                        m_state <= 2'd3; m_entry <= cyc + 1; m_to <= 1'b1;
                    end
                end
                default: if (cyc + 1 - m_entry >= MOFF) begin
                    m_state <= 2'd0; m_entry <= cyc + 1;
                end
            endcase
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic step();
        logic [5:0] act, exp;
        @(negedge clk);
        act = {ce, stop_req, state_o, en_filtered, timeout_o};
        exp = {(m_state == 2'd1) || (m_state == 2'd2), m_state == 2'd2, m_state, m_en, m_to};
        chk("cycle_vs_model", int'(act), int'(exp));
    endtask

    initial begin
        int n;
        logic seen;
        // 1. reset with key held, then power-up latency
        key_en = 1'b1;
        repeat (3) step();
        chk("reset_outputs", int'({ce, stop_req, state_o, en_filtered, timeout_o}), 0);
        rst_n = 1'b1;
        n = 0;
        do begin step(); n++; end while (!ce && n < 20);
        chk("ce_rise_after_reset", n, 7);
        chk("stop_req_low_on", int'(stop_req), 0);
        $display("reset release: ce rose after %0d edges", n);

        // 3. normal stop with acknowledge
        repeat (20) step();
        key_en = 1'b0;
        n = 0;
        while (!stop_req && n < 40) begin step(); n++; end
        chk("stop_req_rise", int'(stop_req), 1);
        step(); step();
        stop_ack = 1'b1;
        step();
        stop_ack = 1'b0;
        chk("ack_ce_fall", int'(ce), 0);
        chk("ack_stop_req_fall", int'(stop_req), 0);
        chk("ack_state_hold", int'(state_o), 3);
        n = 1;
        while (n < 20) begin step(); if (state_o != 2'd3) break; n++; end
        chk("hold_off_len", n, MOFF);
        chk("state_after_hold", int'(state_o), 0);
        $display("normal stop: hold_off lasted %0d cycles", n);

        // 4. acknowledge timeout
        key_en = 1'b1;
        n = 0;
        while (!ce && n < 30) begin step(); n++; end
        repeat (20) step();
        key_en = 1'b0;
        n = 0;
        while (!stop_req && n < 40) begin step(); n++; end
        n = 1;
        while (n < 30) begin step(); if (!stop_req) break; n++; end
        chk("stop_req_width", n, ATO);
        chk("timeout_pulse", int'(timeout_o), 1);
        chk("timeout_ce_low", int'(ce), 0);
        step();
        chk("timeout_one_cycle", int'(timeout_o), 0);
        $display("timeout: stop_req high %0d cycles", n);

        // 2. bounce rejection from OFF
        n = 0;
        while (state_o != 2'd0 && n < 20) begin step(); n++; end
        chk("bounce_start_off", int'(state_o), 0);
        seen = 1'b0;
        key_en = 1'b1;
        repeat (3) begin step(); seen |= ce | en_filtered; end
        for (int i = 0; i < 10; i++) begin
            key_en = (i % 2 == 1);
            step(); seen |= ce | en_filtered;
        end
        key_en = 1'b0;
        repeat (10) begin step(); seen |= ce | en_filtered; end
        chk("bounce_ignored", int'(seen), 0);
        $display("bounce: enable seen=%0d", seen);

        // 5. minimum on time, abort, ack-over-abort priority
        key_en = 1'b1;
        n = 0;
        while (!ce && n < 30) begin step(); n++; end
        key_en = 1'b0;
        n = 1;
        while (n < 30) begin step(); if (state_o != 2'd1) break; n++; end
        chk("min_on_len", n, MON);
        chk("min_on_then_drain", int'(state_o), 2);
        key_en = 1'b1;
        n = 0;
        while (state_o != 2'd1 && n < 15) begin step(); n++; end
        chk("abort_state", int'(state_o), 1);
        chk("abort_stop_req", int'(stop_req), 0);
        key_en = 1'b0;
        n = 0;
        while (state_o != 2'd2 && n < 40) begin step(); n++; end
        key_en = 1'b1;
        n = 0;
        while (!en_filtered && n < 15) begin step(); n++; end
        stop_ack = 1'b1;
        step();
        stop_ack = 1'b0;
        chk("ack_beats_abort", int'(state_o), 3);
        chk("ack_no_timeout", int'(timeout_o), 0);
        $display("priority: state after ack+abort = %0d", state_o);

        // 6. asynchronous reset in DRAIN
        n = 0;
        while (!ce && n < 40) begin step(); n++; end
        key_en = 1'b0;
        while (!stop_req && n < 80) begin step(); n++; end
        chk("drain_before_reset", int'(stop_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ce_low", int'(ce), 0);
        chk("async_stop_req_low", int'(stop_req), 0);
        chk("async_state_off", int'(state_o), 0);
        key_en = 1'b1;
        step(); step();
        rst_n = 1'b1;
        n = 0;
        do begin step(); n++; end while (!ce && n < 20);
        chk("ce_rise_after_rereset", n, 7);
        $display("mid-drain reset: ce rose after %0d edges", n);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
